// File: rtl/niosii_nios2_gen2_0_cpu_debug_host.sv
// System-clock initiator for the CPU debug slave's virtual-JTAG port: each accepted
// command runs one UIR/CDR/SDR/UDR scan on a divided tck and returns the captured DR.
module niosii_nios2_gen2_0_cpu_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int               BIT_W     = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [7:0]       HALF_LAST = 8'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP} state_t;

    state_t              r_state;
    logic [7:0]          r_half_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DR_WIDTH-1:0] r_tx;
    logic [DR_WIDTH-1:0] r_rx;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [IR_WIDTH-1:0] r_rsp_ir_out;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_tck;
    logic                r_tdi;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_udr;
    logic                r_rti;
    logic                r_cmd_ready;
    logic                r_rsp_valid;

    logic                w_term;
    logic                w_rise;
    logic                w_fall;
    logic [DR_WIDTH-1:0] w_tx_next;

    // A tck period is two half-periods; the falling toggle closes the period.
    assign w_term    = (r_half_cnt == HALF_LAST);
    assign w_rise    = w_term && !r_tck;
    assign w_fall    = w_term && r_tck;
    assign w_tx_next = r_tx >> 1;

    // NOTE: every register here uses non-blocking assignment so each update on an
    // edge sees the pre-edge values of all the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_half_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_rsp_dr     <= '0;
            r_rsp_ir_out <= '0;
            r_ir_in      <= '0;
            r_tck        <= 1'b0;
            r_tdi        <= 1'b0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b1;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_ir_in     <= cmd_ir;
                        r_tx        <= cmd_dr;
                        r_rx        <= '0;
                        r_half_cnt  <= '0;
                        r_tck       <= 1'b0;
                        r_uir       <= 1'b1;
                        r_rti       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_UIR;
                    end
                end
                S_UIR, S_CDR, S_SDR, S_UDR: begin
                    if (w_term) begin
                        r_half_cnt <= '0;
                        r_tck      <= ~r_tck;
                    end else begin
                        r_half_cnt <= r_half_cnt + 8'd1;
                    end
                    if (w_rise && r_state == S_SDR) begin
                        r_rx <= {vji_tdo, r_rx[DR_WIDTH-1:1]};
                    end
                    // Strobes and tdi only move here, so they are stable around each rising tck.
                    if (w_fall) begin
                        case (r_state)
                            S_UIR: begin
                                r_uir   <= 1'b0;
                                r_cdr   <= 1'b1;
                                r_state <= S_CDR;
                            end
                            S_CDR: begin
                                r_cdr     <= 1'b0;
                                r_sdr     <= 1'b1;
                                r_bit_cnt <= '0;
                                r_tdi     <= r_tx[0];
                                r_state   <= S_SDR;
                            end
                            S_SDR: begin
                                r_tx <= w_tx_next;
                                if (r_bit_cnt == BIT_LAST) begin
                                    r_sdr   <= 1'b0;
                                    r_udr   <= 1'b1;
                                    r_tdi   <= 1'b0;
                                    r_state <= S_UDR;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    r_tdi     <= w_tx_next[0];
                                end
                            end
                            S_UDR: begin
                                r_udr        <= 1'b0;
                                r_rsp_dr     <= r_rx;
                                r_rsp_ir_out <= vji_ir_out;
                                r_rsp_valid  <= 1'b1;
                                r_state      <= S_RSP;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RSP: begin
                    r_rti       <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir_out;
    assign vji_tck    = r_tck;
    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = r_uir;
    assign vji_cdr    = r_cdr;
    assign vji_sdr    = r_sdr;
    assign vji_udr    = r_udr;
    assign vji_rti    = r_rti;

endmodule
